// File: rtl/alu_issue_arbiter_if.sv
// Shared types and the issue/CDB bundle for the ALU issue arbiter.
//   alu_issue_arbiter_pkg : ALU op packet and select/function encodings
//   alu_issue_arbiter_if  : per-port requests and grants, CDB result handshake
//     slave  modport - the arbiter (consumes requests, drives the CDB)
//     master modport - reservation stations and the CDB consumer

package alu_issue_arbiter_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_func_t;

  typedef enum logic [1:0] {
    OPA_IS_RS1  = 2'd0,
    OPA_IS_NPC  = 2'd1,
    OPA_IS_PC   = 2'd2,
    OPA_IS_ZERO = 2'd3
  } opa_sel_t;

  typedef enum logic [1:0] {
    OPB_IS_RS2   = 2'd0,
    OPB_IS_I_IMM = 2'd1,
    OPB_IS_U_IMM = 2'd2
  } opb_sel_t;

  typedef struct packed {
    logic [DATA_W-1:0] rs1_value;
    logic [DATA_W-1:0] rs2_value;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] npc;
    logic [DATA_W-1:0] inst;
    opa_sel_t          opa_sel;
    opb_sel_t          opb_sel;
    alu_func_t         alu_func;
  } alu_packet_t;

endpackage

interface alu_issue_arbiter_if
  import alu_issue_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 6
) ();

  logic [NUM_REQ-1:0]                 req_valid;
  alu_packet_t [NUM_REQ-1:0]          req_packet;
  logic [NUM_REQ-1:0][TAG_W-1:0]      req_tag;
  logic [NUM_REQ-1:0]                 req_grant;
  logic                               cdb_valid;
  logic                               cdb_ready;
  logic [TAG_W-1:0]                   cdb_tag;
  logic [DATA_W-1:0]                  cdb_result;

  modport slave (
    input  req_valid, req_packet, req_tag, cdb_ready,
    output req_grant, cdb_valid, cdb_tag, cdb_result
  );

  modport master (
    output req_valid, req_packet, req_tag, cdb_ready,
    input  req_grant, cdb_valid, cdb_tag, cdb_result
  );

endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ issue ports.
// Granted op -> stage 1 (issue register) -> ALU -> stage 2 (result register)
// -> CDB valid/ready handshake. Flush squashes both stages.
//   clock, reset_n : clock, asynchronous active-low reset
//   flush          : synchronous squash of in-flight ops
//   bus            : requests/grants and CDB result (slave side)
//   busy           : an op is held in either stage

module alu_issue_arbiter
  import alu_issue_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 6
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush,
  alu_issue_arbiter_if.slave  bus,
  output logic                busy
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr;
  logic               s1_valid;
  alu_packet_t        s1_packet;
  logic [TAG_W-1:0]   s1_tag;
  logic               s2_valid;
  logic [DATA_W-1:0]  s2_result;
  logic [TAG_W-1:0]   s2_tag;

  logic               adv1_c;
  logic               adv2_c;
  logic [NUM_REQ-1:0] grant_c;
  logic [PTR_W-1:0]   grant_idx_c;
  logic               grant_hit_c;
  logic [PTR_W-1:0]   cand_c;
  logic [PTR_W-1:0]   rr_next_c;
  logic [DATA_W-1:0]  alu_result_c;

  // Advance chain: a draining CDB frees stage 2, which frees stage 1 in the same cycle
  assign adv2_c = !s2_valid || bus.cdb_ready;
  assign adv1_c = !s1_valid || adv2_c;

  // Round-robin search starting at rr_ptr; first hit wins
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    grant_hit_c = 1'b0;
    cand_c      = '0;
    if (reset_n && adv1_c && !flush) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cand_c = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
        if (!grant_hit_c && bus.req_valid[cand_c]) begin
          grant_hit_c     = 1'b1;
          grant_idx_c     = cand_c;
          grant_c[cand_c] = 1'b1;
        end
      end
    end
  end

  assign rr_next_c = (grant_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + PTR_W'(1);

  alu_issue_arbiter_alu u_alu (
    .packet (s1_packet),
    .result (alu_result_c)
  );

  // Pipeline state; flush empties both stages but leaves rr_ptr alone
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      s1_valid  <= 1'b0;
      s1_packet <= '0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_tag    <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (adv1_c) begin
        s1_valid <= grant_hit_c;
        if (grant_hit_c) begin
          s1_packet <= bus.req_packet[grant_idx_c];
          s1_tag    <= bus.req_tag[grant_idx_c];
          rr_ptr    <= rr_next_c;
        end
      end
      if (adv2_c) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_result <= alu_result_c;
          s2_tag    <= s1_tag;
        end
      end
    end
  end

  assign bus.req_grant  = grant_c;
  assign bus.cdb_valid  = s2_valid;
  assign bus.cdb_tag    = s2_tag;
  assign bus.cdb_result = s2_result;
  assign busy           = s1_valid || s2_valid;

endmodule

// Combinational ALU: operand selection followed by the function unit
module alu_issue_arbiter_alu
  import alu_issue_arbiter_pkg::*;
(
  input  alu_packet_t        packet,
  output logic [DATA_W-1:0]  result
);

  logic [DATA_W-1:0] opa_c;
  logic [DATA_W-1:0] opb_c;
  logic              unused_inst;

  // Opcode/rd bits are decoded upstream; only the immediate fields matter here
  assign unused_inst = ^packet.inst[11:0];

  always_comb begin
    opa_c = '0;
    opb_c = '0;
    case (packet.opa_sel)
      OPA_IS_RS1: opa_c = packet.rs1_value;
      OPA_IS_NPC: opa_c = packet.npc;
      OPA_IS_PC:  opa_c = packet.pc;
      default:    opa_c = '0;
    endcase
    case (packet.opb_sel)
      OPB_IS_RS2:   opb_c = packet.rs2_value;
      OPB_IS_I_IMM: opb_c = {{20{packet.inst[31]}}, packet.inst[31:20]};
      OPB_IS_U_IMM: opb_c = {packet.inst[31:12], 12'b0};
      default:      opb_c = '0;
    endcase
  end

  always_comb begin
    result = '0;
    case (packet.alu_func)
      ALU_ADD:  result = opa_c + opb_c;
      ALU_SUB:  result = opa_c - opb_c;
      ALU_SLT:  result = {31'b0, ($signed(opa_c) < $signed(opb_c))};
      ALU_SLTU: result = {31'b0, (opa_c < opb_c)};
      ALU_AND:  result = opa_c & opb_c;
      ALU_OR:   result = opa_c | opb_c;
      ALU_XOR:  result = opa_c ^ opb_c;
      ALU_SLL:  result = opa_c << opb_c[4:0];
      ALU_SRL:  result = opa_c >> opb_c[4:0];
      ALU_SRA:  result = DATA_W'($signed(opa_c) >>> opb_c[4:0]);
      default:  result = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: reset, single op, round-robin,
// backpressure, flush, ALU corners and asynchronous reset mid-operation.
// Inputs change 1 time unit after a rising edge; outputs are sampled 4 units after.

module tb_alu_issue_arbiter;
  import alu_issue_arbiter_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned TAG_W   = 6;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned NOPS    = 11;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic flush   = 1'b0;
  logic busy;

  alu_issue_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

  alu_issue_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_cdb(input string tag, input logic [TAG_W-1:0] t, input logic [31:0] r);
    check({tag, "_valid"},  32'(bus.cdb_valid), 32'd1);
    check({tag, "_tag"},    32'(bus.cdb_tag), 32'(t));
    check({tag, "_result"}, bus.cdb_result, r);
  endtask

  function automatic alu_packet_t mk(input alu_func_t f, input logic [31:0] a, input logic [31:0] b);
    alu_packet_t p;
    p           = '0;
    p.rs1_value = a;
    p.rs2_value = b;
    p.opa_sel   = OPA_IS_RS1;
    p.opb_sel   = OPB_IS_RS2;
    p.alu_func  = f;
    return p;
  endfunction

  task automatic set_pkt(input logic [PTR_W-1:0] port, input alu_packet_t p, input logic [TAG_W-1:0] t);
    bus.req_packet[port] = p;
    bus.req_tag[port]    = t;
    bus.req_valid[port]  = 1'b1;
  endtask

  task automatic set_op(input logic [PTR_W-1:0] port, input alu_func_t f,
                        input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    set_pkt(port, mk(f, a, b), t);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  alu_packet_t       pk [NOPS];
  logic [31:0]       ex [NOPS];
  logic [NUM_REQ-1:0] g_exp;
  int                gp;
  int                op;
  int                k_exp;
  logic              grant_on;

  initial begin
    bus.req_valid  = '0;
    bus.req_packet = '0;
    bus.req_tag    = '0;
    bus.cdb_ready  = 1'b1;

    // ---- reset state, grants held off while in reset ----
    for (int p = 0; p < 4; p++) set_op(PTR_W'(p), ALU_ADD, 32'd1, 32'd1, TAG_W'(p));
    #2;
    check("rst_grant",  32'(bus.req_grant), 32'd0);
    check("rst_valid",  32'(bus.cdb_valid), 32'd0);
    check("rst_tag",    32'(bus.cdb_tag), 32'd0);
    check("rst_result", bus.cdb_result, 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    bus.req_valid = '0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    next_cycle();

    // ---- single op ----
    set_op(PTR_W'(2), ALU_ADD, 32'd5, 32'd7, TAG_W'(9));
    #3;
    check("single_grant", 32'(bus.req_grant), 32'h4);
    next_cycle();
    bus.req_valid = '0;
    #3;
    check("single_c1_valid", 32'(bus.cdb_valid), 32'd0);
    check("single_c1_busy",  32'(busy), 32'd1);
    next_cycle();
    #3;
    chk_cdb("single_c2", TAG_W'(9), 32'd12);
    check("single_rr_ptr", 32'(dut.rr_ptr), 32'd3);
    next_cycle();
    #3;
    check("single_c3_valid", 32'(bus.cdb_valid), 32'd0);
    check("single_c3_busy",  32'(busy), 32'd0);
    next_cycle();

    // ---- round robin, all ports requesting, rr_ptr starts at 3 ----
    for (int p = 0; p < 4; p++) set_op(PTR_W'(p), ALU_ADD, 32'(10 * p), 32'd1, TAG_W'(16 + p));
    for (int k = 0; k < 8; k++) begin
      if (k == 6) bus.req_valid = '0;
      #3;
      g_exp = (k < 6) ? NUM_REQ'(1) << ((3 + k) % 4) : '0;
      check("rr_grant", 32'(bus.req_grant), 32'(g_exp));
      if (k >= 2) begin
        gp = (3 + k - 2) % 4;
        chk_cdb("rr_cdb", TAG_W'(16 + gp), 32'(10 * gp + 1));
      end
      next_cycle();
    end

    // ---- backpressure on port 1: cdb_ready low for cycles 3..6 ----
    op = 0;
    for (int c = 0; c < 11; c++) begin
      bus.cdb_ready = !(c >= 3 && c <= 6);
      if (c >= 2 && c <= 7) set_op(PTR_W'(1), ALU_ADD, 32'(3 * op + 1), 32'd40, TAG_W'(32 + op));
      else bus.req_valid = '0;
      grant_on = (c >= 2 && c <= 7) && !(c >= 4 && c <= 6);
      #3;
      check("bp_grant", 32'(bus.req_grant), grant_on ? 32'h2 : 32'h0);
      if (c >= 4 && c <= 7)      k_exp = 0;
      else if (c == 8)           k_exp = 1;
      else if (c == 9)           k_exp = 2;
      else                       k_exp = -1;
      if (k_exp >= 0) chk_cdb("bp_cdb", TAG_W'(32 + k_exp), 32'(3 * k_exp + 41));
      else check("bp_idle", 32'(bus.cdb_valid), 32'd0);
      if (c == 5) check("bp_busy", 32'(busy), 32'd1);
      next_cycle();
      if (grant_on) op++;
    end
    bus.cdb_ready = 1'b1;

    // ---- flush with both stages full, rr_ptr starts at 2 ----
    set_op(PTR_W'(3), ALU_SUB, 32'd100, 32'd1, TAG_W'(3));
    set_op(PTR_W'(0), ALU_XOR, 32'h0000F0F0, 32'h00000FF0, TAG_W'(4));
    #3;
    check("fl_grant0", 32'(bus.req_grant), 32'h8);
    next_cycle();
    #3;
    check("fl_grant1", 32'(bus.req_grant), 32'h1);
    next_cycle();
    flush = 1'b1;
    #3;
    check("fl_grant_flush", 32'(bus.req_grant), 32'h0);
    chk_cdb("fl_delivered", TAG_W'(3), 32'd99);
    next_cycle();
    flush = 1'b0;
    #3;
    check("fl_valid_after", 32'(bus.cdb_valid), 32'd0);
    check("fl_busy_after",  32'(busy), 32'd0);
    check("fl_rr_ptr",      32'(dut.rr_ptr), 32'd1);
    check("fl_regrant",     32'(bus.req_grant), 32'h8);
    next_cycle();
    bus.req_valid = '0;
    #3;
    check("fl_idle_grant", 32'(bus.req_grant), 32'h0);
    next_cycle();
    #3;
    chk_cdb("fl_post", TAG_W'(3), 32'd99);
    next_cycle();
    #3;
    check("fl_drained", 32'(bus.cdb_valid), 32'd0);
    next_cycle();

    // ---- ALU corners, back-to-back on port 2 ----
    pk[0] = mk(ALU_SRA,  32'h80000000, 32'd4);        ex[0] = 32'hF8000000;
    pk[1] = mk(ALU_SLT,  32'hFFFFFFFF, 32'd1);        ex[1] = 32'd1;
    pk[2] = mk(ALU_SLTU, 32'hFFFFFFFF, 32'd1);        ex[2] = 32'd0;
    pk[3] = mk(ALU_SUB,  32'd0, 32'd1);               ex[3] = 32'hFFFFFFFF;
    pk[4] = mk(ALU_SLL,  32'd1, 32'h21);              ex[4] = 32'd2;
    pk[5] = mk(ALU_SRL,  32'h80000000, 32'd31);       ex[5] = 32'd1;
    pk[6] = mk(ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0); ex[6] = 32'h00F000F0;
    pk[7] = mk(ALU_OR,   32'h00000F00, 32'h000000F0); ex[7] = 32'h00000FF0;
    pk[8] = mk(ALU_ADD,  32'hFFFFFFFF, 32'd2);        ex[8] = 32'd1;
    pk[9] = mk(ALU_ADD,  32'd0, 32'd0);
    pk[9].pc = 32'h00001000; pk[9].inst = 32'hFFC00013;
    pk[9].opa_sel = OPA_IS_PC; pk[9].opb_sel = OPB_IS_I_IMM;   ex[9] = 32'h00000FFC;
    pk[10] = mk(ALU_ADD, 32'd0, 32'd0);
    pk[10].npc = 32'h00002004; pk[10].inst = 32'h12345037;
    pk[10].opa_sel = OPA_IS_NPC; pk[10].opb_sel = OPB_IS_U_IMM; ex[10] = 32'h12347004;
    for (int c = 0; c < NOPS + 2; c++) begin
      if (c < NOPS) set_pkt(PTR_W'(2), pk[c], TAG_W'(40 + c));
      else bus.req_valid = '0;
      #3;
      check("alu_grant", 32'(bus.req_grant), (c < NOPS) ? 32'h4 : 32'h0);
      if (c >= 2) chk_cdb("alu_cdb", TAG_W'(40 + c - 2), ex[c - 2]);
      next_cycle();
    end
    #3;
    check("alu_drained", 32'(bus.cdb_valid), 32'd0);
    next_cycle();

    // ---- asynchronous reset while stage 2 holds a result ----
    set_op(PTR_W'(1), ALU_ADD, 32'd1, 32'd2, TAG_W'(5));
    next_cycle();
    bus.req_valid = '0;
    next_cycle();
    for (int p = 0; p < 4; p++) set_op(PTR_W'(p), ALU_ADD, 32'(p), 32'd1000, TAG_W'(50 + p));
    #1;
    chk_cdb("ar_before", TAG_W'(5), 32'd3);
    #1;
    reset_n = 1'b0;
    #1;
    check("ar_valid",  32'(bus.cdb_valid), 32'd0);
    check("ar_tag",    32'(bus.cdb_tag), 32'd0);
    check("ar_result", bus.cdb_result, 32'd0);
    check("ar_busy",   32'(busy), 32'd0);
    check("ar_grant",  32'(bus.req_grant), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("ar_first_grant", 32'(bus.req_grant), 32'h1);
    next_cycle();
    #3;
    check("ar_second_grant", 32'(bus.req_grant), 32'h2);
    next_cycle();
    bus.req_valid = '0;
    #3;
    chk_cdb("ar_post0", TAG_W'(50), 32'd1000);
    next_cycle();
    #3;
    chk_cdb("ar_post1", TAG_W'(51), 32'd1001);
    next_cycle();
    #3;
    check("ar_drained", 32'(bus.cdb_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares one ALU functional unit among NUM_REQ reservation-station issue ports using round-robin arbitration.
- Sequences each granted op through a two-stage pipeline: issue register, then the combinational alu instance, then the result register.
- Delivers results to the CDB over a valid/ready handshake, with backpressure, and squashes in-flight ops on flush.

Parameters:
NUM_REQ, 4, number of requesting issue ports (>=2)
TAG_W, 6, physical destination register tag width

Ports:
clock  in  1  system clock, all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
flush  in  1  branch-mispredict squash, synchronous
req_valid  in  NUM_REQ  per-port request valid
req_packet  in  NUM_REQ x ALU_PACKET  per-port op packet (operands, PC/NPC, inst, select fields, alu_func)
req_tag  in  NUM_REQ x TAG_W  per-port destination tag
req_grant  out  NUM_REQ  one-hot grant, combinational, same cycle as request
cdb_valid  out  1  result valid to CDB
cdb_ready  in  1  CDB accepts result this cycle
cdb_tag  out  TAG_W  destination tag of result
cdb_result  out  32  ALU result (DATA)
busy  out  1  s1_valid | s2_valid

Behaviour:
- Reset value of every output and all state (asynchronous on reset_n=0): s1_valid=0, s2_valid=0, rr_ptr=0, stage data registers 0, cdb_valid=0, cdb_tag=0, cdb_result=0, busy=0. req_grant=0 while reset_n=0.
- Stage 1 (issue register) holds packet, tag and s1_valid. Stage 2 (result register) holds result, tag and s2_valid.
- adv2 = !s2_valid | cdb_ready. adv1 = !s1_valid | adv2.
- Arbitration: if adv1 and !flush, grant the first port with req_valid=1, searching upward from rr_ptr with wrap modulo NUM_REQ. Otherwise req_grant=0. At most one grant bit is set.
- On a grant to port g: stage 1 loads req_packet[g] and req_tag[g]; s1_valid<=1; rr_ptr<=(g+1) mod NUM_REQ. With no grant, rr_ptr is unchanged.
- If adv1 with no grant: s1_valid<=0, unless stage 1 is stalled (adv1=0), in which case it holds.
- If adv2 and s1_valid: stage 2 loads the alu result computed from stage 1, plus stage 1's tag; s2_valid<=1.
- If adv2 and !s1_valid: s2_valid<=0.
- If !adv2: stage 2 holds; cdb_tag and cdb_result stay stable while cdb_valid=1.
- cdb_valid=s2_valid. A handshake completes on cdb_valid & cdb_ready.
- Latency: grant at cycle N gives cdb_valid at cycle N+2. Throughput is 1 op/cycle while cdb_ready=1. At most 2 ops are in flight.
- Simultaneous stall release: cdb_ready rising in cycle N permits a grant in cycle N (combinational adv chain).
- Flush: req_grant=0 that cycle. Next edge s1_valid<=0 and s2_valid<=0; rr_ptr is unchanged. A result handshaked in the flush cycle counts as delivered.
- reset_n asserted mid-operation drops all in-flight ops immediately; no partial CDB result is produced.
- Arithmetic: 32-bit, wrap-around add/sub. Shifts use opb[4:0]. SLT/SLTU yield 0 or 1.

Test Plan:
- Single op: port 2 requests ALU_ADD, rs1=5, rs2=7, tag=9 at cycle 0 -> req_grant=4'b0100 at cycle 0; cdb_valid=1, cdb_result=12, cdb_tag=9 at cycle 2; rr_ptr=3.
- Round-robin fairness: all 4 ports valid continuously, cdb_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; one result per cycle from cycle 2.
- Backpressure: a stream of ops with cdb_ready=0 from cycle 3 -> stage 2 holds its result and tag stable; stage 1 fills; req_grant=0 from cycle 4. Raising cdb_ready at cycle 7 -> handshake and a new grant both occur at cycle 7.
- Flush: ops in both stages, flush=1 at cycle 5 -> req_grant=0 at cycle 5; cdb_valid=0 and busy=0 at cycle 6; rr_ptr unchanged.
- Reset mid-op: reset_n=0 asynchronously between edges with s2_valid=1 -> cdb_valid, cdb_tag and cdb_result go to 0 immediately; after release, first grant goes to port 0.
- Arithmetic corners: ALU_SRA with 0x80000000 and shift 4 -> 0xF8000000. ALU_SLT with 0xFFFFFFFF and 1 -> 1. ALU_SLTU with the same operands -> 0. ALU_SUB 0-1 -> 0xFFFFFFFF.
